// File: rtl/vga_link_pkg.sv
// rtl/vga_link_pkg.sv - shared opcodes, FSM states and frame constants for the VGA write link
// Contents: op_e command opcodes, state_e controller states, frame length,
//           colour prefix, substitute range and the CHAR byte substitution helper.
package vga_link_pkg;

    typedef enum logic [1:0] {
        OP_CHAR   = 2'b00,
        OP_ROW    = 2'b01,
        OP_COLOUR = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_SYNC0,
        ST_SYNC1,
        ST_IDLE,
        ST_FRAME
    } state_e;

    localparam int         FRAME_BITS    = 9;
    localparam logic [1:0] COLOUR_PREFIX = 2'b10;
    localparam logic [7:0] COLOUR_LO     = 8'h80;
    localparam logic [7:0] COLOUR_HI     = 8'hBF;

    // Codes in the colour range would be taken as colour commands by the
    // display, so they are never sent as characters.
    function automatic logic [7:0] char_byte(input logic [7:0] data, input logic [7:0] sub);
        return (data >= COLOUR_LO && data <= COLOUR_HI) ? sub : data;
    endfunction

endpackage

// File: rtl/vga_link_shifter.sv
// rtl/vga_link_shifter.sv - serialises one byte plus latch pulse onto wclk/d0/dc/cs
// Ports: clk25, rst (async, active-high); load, load_byte, load_cs start a frame;
//        wclk, d0, dc, cs link pins; active while a frame runs;
//        frame_end is high on the last cycle of a frame (combinational).
module vga_link_shifter
    import vga_link_pkg::*;
#(
    parameter int HALF = 2
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       load_cs,
    output logic       wclk,
    output logic       d0,
    output logic       dc,
    output logic       cs,
    output logic       active,
    output logic       frame_end
);

    localparam int            CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] HMAX = CW'(HALF - 1);
    localparam logic [3:0]    LAST = 4'(FRAME_BITS - 1);
    localparam logic [3:0]    PRE  = 4'(FRAME_BITS - 2);

    logic [CW-1:0] hcnt;
    logic [3:0]    bit_idx;
    logic [6:0]    shreg;
    logic          half_end;

    assign half_end  = (hcnt == HMAX);
    assign frame_end = active && wclk && half_end && (bit_idx == LAST);

    // Data pins only move together with the falling wclk edge, centring
    // every rising edge in a stable window of HALF cycles on each side.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            hcnt    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            wclk    <= 1'b0;
            d0      <= 1'b0;
            dc      <= 1'b0;
            cs      <= 1'b0;
        end else if (load) begin
            active  <= 1'b1;
            hcnt    <= '0;
            bit_idx <= '0;
            shreg   <= load_byte[7:1];
            wclk    <= 1'b0;
            d0      <= load_byte[0];
            dc      <= 1'b1;
            cs      <= load_cs;
        end else if (active) begin
            if (!half_end) begin
                hcnt <= hcnt + 1'b1;
            end else begin
                hcnt <= '0;
                if (!wclk) begin
                    wclk <= 1'b1;
                end else if (bit_idx == LAST) begin
                    active <= 1'b0;
                    wclk   <= 1'b0;
                    d0     <= 1'b0;
                    dc     <= 1'b0;
                    cs     <= 1'b0;
                end else begin
                    wclk    <= 1'b0;
                    bit_idx <= bit_idx + 4'd1;
                    if (bit_idx == PRE) begin
                        // Final period is the latch pulse.
                        dc <= 1'b0;
                        d0 <= 1'b0;
                    end else begin
                        d0    <= shreg[0];
                        shreg <= {1'b0, shreg[6:1]};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/vga_link_ctrl.sv
// rtl/vga_link_ctrl.sv - two-requester arbiter, command validation and cursor shadow for the VGA write link
// Ports: clk25, rst (async, active-high); req_valid/req_ready/req_op/req_data per-requester
//        command handshake; wclk, d0, dc, cs link pins; busy, done, err status;
//        grant_id last accepted requester; cursor_addr shadow of display write address.
module vga_link_ctrl
    import vga_link_pkg::*;
#(
    parameter int         HALF     = 2,
    parameter int         COLS     = 80,
    parameter int         ROWS     = 60,
    parameter logic [7:0] SUB_CHAR = 8'h3F
) (
    input  logic        clk25,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_data,
    output logic        wclk,
    output logic        d0,
    output logic        dc,
    output logic        cs,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        grant_id,
    output logic [12:0] cursor_addr
);

    state_e     state;
    logic       rr;
    op_e        lat_op;
    logic [7:0] lat_data;

    logic       accept;
    logic       sel;
    op_e        op_sel;
    logic [7:0] data_sel;
    logic       row_bad;
    logic       cmd_ok;

    logic       sh_load;
    logic [7:0] sh_byte;
    logic       sh_cs;
    logic       sh_active;
    logic       frame_end;

    always_comb begin
        req_ready = 2'b00;
        if (state == ST_IDLE) begin
            req_ready[0] = req_valid[0] && (!rr || !req_valid[1]);
            req_ready[1] = req_valid[1] && ( rr || !req_valid[0]);
        end
    end

    assign accept   = |req_ready;
    assign sel      = req_ready[1];
    assign op_sel   = op_e'(sel ? req_op[3:2] : req_op[1:0]);
    assign data_sel = sel ? req_data[15:8] : req_data[7:0];
    assign row_bad  = int'(data_sel) >= ROWS;
    assign cmd_ok   = accept && ((op_sel == OP_CHAR) || (op_sel == OP_COLOUR) ||
                                 ((op_sel == OP_ROW) && !row_bad));

    // Sync frames chain directly on frame_end; command frames start on accept.
    always_comb begin
        sh_load = 1'b0;
        sh_byte = 8'h00;
        sh_cs   = 1'b0;
        case (state)
            ST_SYNC0: sh_load = !sh_active || frame_end;
            ST_IDLE: begin
                if (cmd_ok) begin
                    sh_load = 1'b1;
                    case (op_sel)
                        OP_CHAR: begin
                            sh_byte = char_byte(data_sel, SUB_CHAR);
                            sh_cs   = 1'b1;
                        end
                        OP_COLOUR: begin
                            sh_byte = {COLOUR_PREFIX, data_sel[5:0]};
                            sh_cs   = 1'b1;
                        end
                        default: begin
                            sh_byte = data_sel;
                            sh_cs   = 1'b0;
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    vga_link_shifter #(.HALF(HALF)) u_shifter (
        .clk25     (clk25),
        .rst       (rst),
        .load      (sh_load),
        .load_byte (sh_byte),
        .load_cs   (sh_cs),
        .wclk      (wclk),
        .d0        (d0),
        .dc        (dc),
        .cs        (cs),
        .active    (sh_active),
        .frame_end (frame_end)
    );

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state       <= ST_SYNC0;
            rr          <= 1'b0;
            lat_op      <= OP_CHAR;
            lat_data    <= 8'h00;
            busy        <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            grant_id    <= 1'b0;
            cursor_addr <= 13'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_SYNC0: begin
                    if (frame_end) state <= ST_SYNC1;
                end
                ST_SYNC1: begin
                    if (frame_end) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        // Pointer moves away from the winner even when the
                        // command is rejected, so a bad requester cannot starve the other.
                        grant_id <= sel;
                        rr       <= ~sel;
                        lat_op   <= op_sel;
                        lat_data <= data_sel;
                        if (cmd_ok) begin
                            state <= ST_FRAME;
                            busy  <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_FRAME: begin
                    if (frame_end) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        case (lat_op)
                            OP_CHAR: cursor_addr <= cursor_addr + 13'd1;
                            OP_ROW:  cursor_addr <= 13'(int'(lat_data) * COLS);
                            default: ;
                        endcase
                    end
                end
                default: state <= ST_SYNC0;
            endcase
        end
    end

endmodule

// File: doc/vga_link_ctrl.md
# vga_link_ctrl

- Host-side controller for the text-mode VGA terminal's serial write link (`wclk`/`d0`/`dc`/`cs`).
- Arbitrates round-robin between two requesters issuing CHAR, ROW and COLOUR commands. Serialises each accepted command as one 9-pulse frame and keeps a shadow copy of the display's write address.
- Sits in the host FPGA/MCU-side logic, driving the pins wired to the display core.

## Interface
Parameters:
- `HALF`, 2: `wclk` half-period in `clk25` cycles; must be ≥1.
- `COLS`, 80: characters per row; used for the cursor multiply.
- `ROWS`, 60: valid rows are 0..ROWS-1.
- `SUB_CHAR`, 8'h3F: substitute for CHAR codes 0x80–0xBF.

Ports:
- `clk25`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  2  per-requester command valid.
- `req_ready`  out  2  per-requester accept; handshake completes when valid&ready.
- `req_op`  in  4  opcodes, `[1:0]`=req0, `[3:2]`=req1: 00 CHAR, 01 ROW, 10 COLOUR, 11 reserved.
- `req_data`  in  16  payloads, `[7:0]`=req0, `[15:8]`=req1.
- `wclk`  out  1  link clock; display samples on its rising edge.
- `d0`  out  1  serial data bit, LSB first.
- `dc`  out  1  1 = data bit, 0 = latch pulse.
- `cs`  out  1  1 = char/colour frame, 0 = row frame.
- `busy`  out  1  frame or sync in progress.
- `done`  out  1  1-cycle pulse at the end of a requested frame.
- `err`  out  1  1-cycle pulse when a command is rejected.
- `grant_id`  out  1  requester of the last accepted command.
- `cursor_addr`  out  13  shadow of the display write address.

## Operation
- States: SYNC0, SYNC1, IDLE, FRAME.
- Reset values: `wclk`=`d0`=`dc`=`cs`=0, `req_ready`=0, `busy`=1, `done`=`err`=0, `grant_id`=0, `cursor_addr`=0, RR pointer=0, state SYNC0.
- **SYNC0/SYNC1**
  - Each sends a ROW frame with byte 0x00, with no `done`.
  - Purpose: the display's bit counter clears only on a latch, so a reset mid-frame leaves it misaligned. Two frames guarantee realignment and row 0.
- **IDLE**
  - `busy`=0.
  - `req_ready[i]` is combinational: `req_valid[i]` && (RR pointer==i || !`req_valid[1-i]`).
  - At most one bit is set.
- **Accept**
  - Latch op/data.
  - Set `grant_id`.
  - Set RR pointer to 1-`grant_id`; this happens for rejected commands too.
- **Command handling**
  - CHAR: byte = data, or `SUB_CHAR` if data is in 0x80–0xBF. Frame has `cs`=1. Cursor +1 at `done`, 13-bit wrap 8191→0.
  - ROW: if data ≥ `ROWS`, pulse `err` the next cycle, send no frame, stay IDLE. Otherwise send data with `cs`=0; cursor = data*`COLS` at `done`.
  - COLOUR: byte = {2'b10, data[5:0]}, `cs`=1; cursor unchanged.
  - Reserved op: `err` pulse only.
- **Frame**
  - 9 `wclk` periods.
  - Periods 0–7: `dc`=1, `d0`=byte[k].
  - Period 8: `dc`=0, `d0`=0.
  - `cs` is constant for the whole frame.

## Timing
- Each `wclk` period = HALF cycles low, then HALF cycles high.
- `d0`/`dc`/`cs` change only on the cycle `wclk` goes low. This gives HALF cycles of setup and HALF of hold around each rising edge.
- A frame occupies exactly 18·HALF cycles starting the cycle after acceptance.
- `done` and the cursor update occur on the first cycle after the frame. IDLE is entered in that same cycle, so back-to-back accepts give one idle cycle minimum between frames.
- Between frames: `wclk`=0, `dc`=0, `d0`=0, `cs`=0.
- Reset asserted mid-frame: all outputs take reset values immediately (asynchronous). The sync sequence restarts on release.
- First `req_ready` is possible at cycle 36·HALF after reset release (release edge = cycle 0).
- All outputs are registered except `req_ready`.

## Structure
- Package `vga_link_pkg`:
  - opcode constants;
  - `FRAME_BITS`=9;
  - colour prefix 2'b10;
  - colour range 0x80–0xBF.
- Sub-module `vga_link_shifter`:
  - loads byte+`cs`;
  - generates `wclk` from a HALF counter;
  - shifts `d0`, emits the latch period;
  - returns a `frame_end` strobe.
- `vga_link_ctrl` holds the arbiter, FSM, validation and cursor.

## Test plan
- Reset, HALF=2 → two `cs`=0 frames of byte 0x00 (72 cycles); `req_ready` first possible at cycle 72; `cursor_addr`=0.
- req0 CHAR 0x41 → on rising `wclk` with `dc`=1, `cs`=1: `d0` = 1,0,0,0,0,0,1,0; then one rising edge with `dc`=0; then `done`, `cursor_addr`=1.
- CHAR 0x9A → byte 0x3F serialised; CHAR with cursor 8191 → cursor wraps to 0.
- ROW 5 → `cs`=0 byte 0x05, `cursor_addr`=400; ROW 60 → `err` pulse, no `wclk` edge, cursor unchanged.
- COLOUR 6'b010011 → `cs`=1 byte 0x93, no cursor change; op 11 → `err` only.
- Both `req_valid` held high for 4 commands → grants 0,1,0,1. Then assert `rst` during bit 3 → `wclk`=0 immediately, sync frames replayed, pending requests served after.
